seq_div32: RTL and testbench
============================

SEQ_DIV32 -- requirements
Module: seq_div32

Interface
REQ-001 SHALL have parameter N, default 16, divisor/quotient/remainder width; dividend width is 2N.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair valid.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port dividend  input  2N  unsigned dividend.
REQ-007 SHALL have port divisor  input  N  unsigned divisor.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port quotient  output  N  unsigned quotient.
REQ-011 SHALL have port remainder  output  N  unsigned remainder.
REQ-012 SHALL have port err  output  1  divide-by-zero or quotient overflow (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL accept operands on edge E0 where in_valid&in_ready; operands registered, step counter cleared, state -> CALC.
REQ-016 SHALL in CALC perform one restoring step per edge: shift partial remainder (N+1 bits) left one bit, bring in next dividend bit MSB-first, subtract divisor if result non-negative, shift quotient bit in.
REQ-017 SHALL after the Nth step (edge E0+N) enter DONE; out_valid high from E0+N.
REQ-018 SHALL produce quotient = dividend / divisor and remainder = dividend % divisor whenever divisor != 0 and dividend[2N-1:N] < divisor.
REQ-019 SHALL hold quotient, remainder, err stable while out_valid & !out_ready.
REQ-020 SHALL on edge with out_valid&out_ready go DONE -> IDLE; no operand accept in that same cycle.
REQ-021 SHALL ignore dividend/divisor changes after E0.
REQ-022 SHALL keep quotient/remainder/err at last values in IDLE.

Reset
REQ-023 SHALL on rst_n low, immediately and regardless of state: state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, err=0, counter=0.
REQ-024 SHALL abort any in-flight CALC on reset with no result delivered; first accept after rst_n rises starts a fresh division.

Configuration
REQ-025 SHALL honour macro SEQ_DIV32_ERR_DETECT_EN.
REQ-026 With macro defined: at E0, if divisor==0 or dividend[2N-1:N] >= divisor, SHALL go directly to DONE (out_valid from E0+1... i.e. after one cycle in DONE entry at E0+1), err=1, quotient=all ones, remainder=dividend[N-1:0]; otherwise err=0 and normal latency.
REQ-027 Without macro: err tied 0, every division takes N steps, quotient/remainder unspecified for the REQ-026 error cases.

Structure
REQ-028 SHALL place state enum and default N in shared package seq_div_pkg.
REQ-029 SHALL factor one combinational sub-module div_step (partial remainder in, divisor, next dividend bit -> new partial remainder, quotient bit), instantiated once.

Verification
REQ-030 1000 / 7 -> quotient 142, remainder 6, err 0, out_valid exactly 16 edges after accept.
REQ-031 0xFFFE0001 / 0xFFFF -> quotient 0xFFFF, remainder 0; 0x0000FFFF / 0x0001 -> quotient 0xFFFF, remainder 0.
REQ-032 With macro: 5 / 0 -> err 1, quotient 0xFFFF, remainder 0x0005, out_valid one cycle after accept; 0x00010000 / 0x0001 -> err 1.
REQ-033 out_ready low 5 cycles after 1000/7 completes -> outputs held constant, in_ready 0 throughout; accept occurs only from IDLE after handoff.
REQ-034 rst_n pulsed low at step 8 of a division -> outputs zero immediately, no out_valid; next 1000/7 returns 142/6 with full latency.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// Holds the FSM state encoding and the default divisor width N.
// No logic; imported by div_step and seq_div32.
package seq_div_pkg;

  // Default divisor/quotient/remainder width; dividend is 2*DEF_N bits.
  localparam int DEF_N = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// Purpose: one restoring-division step (shift in a dividend bit, trial subtract).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
//
// Ports:
//   prem      - current partial remainder (N+1 bits, MSB is always 0 in use)
//   divisor   - N-bit divisor
//   dbit      - next dividend bit, fed MSB-first
//   prem_next - partial remainder after the step
//   qbit      - quotient bit produced by the step
module div_step
  import seq_div_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N:0]   prem,
  input  logic [N-1:0] divisor,
  input  logic         dbit,
  output logic [N:0]   prem_next,
  output logic         qbit
);

  logic [N+1:0] shifted;
  logic [N+1:0] diff;

  // One extra bit above the shifted remainder so the borrow of the trial
  // subtraction lands in diff[N+1] and acts as the sign.
  assign shifted   = {prem, dbit};
  assign diff      = shifted - {2'b00, divisor};
  assign qbit      = ~diff[N+1];
  assign prem_next = qbit ? diff[N:0] : shifted[N:0];

endmodule

// File: rtl/seq_div32.sv
// Purpose: unsigned 2N/N sequential restoring divider with valid/ready handshakes.
// Latency: N cycles from accept to out_valid (1 cycle for detected errors).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
//
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - operand handshake (dividend 2N bits, divisor N bits)
//   out_valid / out_ready- result handshake (quotient, remainder, err)
//
// Build option: define SEQ_DIV32_ERR_DETECT_EN to flag divide-by-zero and
// quotient overflow (err=1, quotient all ones, remainder = dividend low half)
// after a single cycle. Without it err is always 0 and every division takes
// N steps.
module seq_div32
  import seq_div_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           err
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  dlo_q;   // low dividend half, shifted out MSB-first
  logic [N-1:0]  dvs_q;
  logic [N-1:0]  quo_q;
  logic [N:0]    rem_q;
  logic          err_q;

  logic          err_chk;
  logic [N:0]    prem_next;
  logic          qbit;

`ifdef SEQ_DIV32_ERR_DETECT_EN
  // The quotient only fits in N bits when the high dividend half is below
  // the divisor; that test also covers divisor == 0.
  assign err_chk = (divisor == '0) || (dividend[2*N-1:N] >= divisor);
`else
  assign err_chk = 1'b0;
`endif

  div_step #(.N(N)) u_step (
    .prem      (rem_q),
    .divisor   (dvs_q),
    .dbit      (dlo_q[N-1]),
    .prem_next (prem_next),
    .qbit      (qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC: begin
        // Errored operands skip the iteration: one CALC cycle, then DONE.
        if (err_q || (cnt_q == CW'(N-1))) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dlo_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      err_q <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      cnt_q <= '0;
      dlo_q <= dividend[N-1:0];
      dvs_q <= divisor;
      err_q <= err_chk;
      if (err_chk) begin
        quo_q <= '1;
        rem_q <= {1'b0, dividend[N-1:0]};
      end else begin
        quo_q <= '0;
        rem_q <= {1'b0, dividend[2*N-1:N]};
      end
    end else if (state_q == CALC && !err_q) begin
      rem_q <= prem_next;
      quo_q <= {quo_q[N-2:0], qbit};
      dlo_q <= {dlo_q[N-2:0], 1'b0};
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q[N-1:0];
  assign err       = err_q;

endmodule

// File: tb/tb_seq_div32.sv
module tb_seq_div32;

  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [2*N-1:0] dividend = '0;
  logic [N-1:0]   divisor = '0;
  logic           in_ready;
  logic           out_valid;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           err;

  always #5 clk = ~clk;

  seq_div32 #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] dvd;
    logic [15:0] dvs;
    logic [15:0] q;
    logic [15:0] r;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Called at posedge+1; returns at posedge(E0)+1 with operands scrambled.
  task automatic start_div(input logic [31:0] a, input logic [15:0] b);
    int t;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) timeout_fail("accept_wait");
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Counts edges after E0 until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (out_valid !== 1'b1) timeout_fail("done_wait");
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  saw_valid;

    vecs[0] = '{32'd1000,       16'd7,      16'd142,    16'd6};
    vecs[1] = '{32'hFFFE0001,   16'hFFFF,   16'hFFFF,   16'h0000};
    vecs[2] = '{32'h0000FFFF,   16'h0001,   16'hFFFF,   16'h0000};
    vecs[3] = '{32'd12345,      16'd100,    16'd123,    16'd45};
    vecs[4] = '{32'h0002FFFF,   16'd3,      16'hFFFF,   16'd2};
    vecs[5] = '{32'h00010000,   16'd2,      16'h8000,   16'd0};
    vecs[6] = '{32'h7FFF8000,   16'h8000,   16'hFFFF,   16'h0000};
    vecs[7] = '{32'hFFFEFFFF,   16'hFFFF,   16'hFFFF,   16'hFFFE};

    // Reset state while rst_n is low.
    #2;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient",  quotient,  0);
    check("rst_remainder", remainder, 0);
    check("rst_err",       err,       0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven normal divisions.
    for (int i = 0; i < 8; i++) begin
      start_div(vecs[i].dvd, vecs[i].dvs);
      check($sformatf("v%0d_in_ready_calc", i), in_ready, 0);
      wait_done(lat);
      check($sformatf("v%0d_latency", i), lat, 16);
      check($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
      check($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
      check($sformatf("v%0d_err", i), err, 0);
      handoff();
      check($sformatf("v%0d_in_ready_idle", i), in_ready, 1);
    end

    // Hold under backpressure; a pending request must not be taken in DONE.
    start_div(32'd1000, 16'd7);
    wait_done(lat);
    in_valid = 1'b1;
    dividend = 32'd5;
    divisor  = 16'd1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_quotient",  quotient,  142);
      check("hold_remainder", remainder, 6);
      check("hold_in_ready",  in_ready,  0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("handoff_out_valid", out_valid, 0);
    check("handoff_in_ready",  in_ready,  1);
    check("idle_keep_quotient", quotient, 142);
    @(posedge clk); #1;
    check("no_stray_accept", in_ready, 1);

    // Reset in the middle of a division.
    start_div(32'd1000, 16'd7);
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_quotient",  quotient,  0);
    check("midrst_remainder", remainder, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready",  in_ready,  1);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) saw_valid = 1'b1;
    end
    check("midrst_no_result", saw_valid, 0);
    start_div(32'd1000, 16'd7);
    wait_done(lat);
    check("postrst_latency",   lat,       16);
    check("postrst_quotient",  quotient,  142);
    check("postrst_remainder", remainder, 6);
    handoff();

`ifdef SEQ_DIV32_ERR_DETECT_EN
    start_div(32'd5, 16'd0);
    wait_done(lat);
    check("dz_latency",   lat,       1);
    check("dz_err",       err,       1);
    check("dz_quotient",  quotient,  16'hFFFF);
    check("dz_remainder", remainder, 16'h0005);
    handoff();
    start_div(32'h00010000, 16'd1);
    wait_done(lat);
    check("ovf_latency",  lat,       1);
    check("ovf_err",      err,       1);
    check("ovf_quotient", quotient,  16'hFFFF);
    check("ovf_remainder", remainder, 16'h0000);
    handoff();
    start_div(32'd1000, 16'd7);
    wait_done(lat);
    check("after_err_err",      err,      0);
    check("after_err_quotient", quotient, 142);
    handoff();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
